mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single DPI physical-memory access port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one transaction at a time on valid/ready request channels and waits a configurable number of cycles.
- Issues exactly one single-cycle memory strobe per transaction, then returns a registered response on a valid/ready response channel.
- Sits between IFU/LSU and the DPI memory wrapper; replaces direct combinational pmem calls with a sequenced, multi-cycle access.

Parameters:
- LATENCY, 1, cycles from request grant to memory strobe (legal range 1..15).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ifu_req_valid  input  1  IFU fetch request.
- ifu_req_ready  output  1  request accepted this cycle.
- ifu_req_addr  input  ADDR_W  fetch address.
- ifu_resp_valid  output  1  fetch data available.
- ifu_resp_ready  input  1  IFU consumes the response.
- ifu_resp_data  output  DATA_W  fetched data.
- lsu_req_valid  input  1  LSU request.
- lsu_req_ready  output  1  request accepted this cycle.
- lsu_req_addr  input  ADDR_W  access address.
- lsu_req_wen  input  1  1 = write, 0 = read.
- lsu_req_wdata  input  DATA_W  store data.
- lsu_req_mask  input  8  byte mask.
- lsu_resp_valid  output  1  load data or store completion available.
- lsu_resp_ready  input  1  LSU consumes the response.
- lsu_resp_data  output  DATA_W  load data; 0 for stores.
- mem_valid  output  1  single-cycle access strobe.
- mem_wen  output  1  write strobe qualifier.
- mem_addr  output  ADDR_W  access address.
- mem_wdata  output  DATA_W  store data.
- mem_mask  output  8  byte mask.
- mem_rdata  input  DATA_W  read data; combinationally valid in the mem_valid cycle.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, counter = 0, last_grant = IFU.
  - All valid/ready outputs 0; mem_* and resp data outputs 0.
- IDLE:
  - req_ready is combinational; it is asserted only to the winner, and only when that requester's valid is high.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the one not in last_grant (round-robin). After reset, the LSU therefore wins the first tie.
  - On handshake: latch addr/wen/wdata/mask and the owner; update last_grant; load counter = LATENCY-1; go to WAIT.
- Request field rules:
  - IFU requests: wen = 0, mask = 8'h0F (32-bit instruction).
  - Addresses and masks pass through unmodified; no alignment check.
- WAIT:
  - Both req_ready outputs are 0.
  - If counter != 0, decrement it.
  - If counter == 0:
    - mem_valid = 1 for this cycle only, with mem_* driven from the latched fields.
    - The owner's resp_data register captures mem_rdata on reads, or 0 on writes.
    - Go to RESP.
- RESP:
  - The owner's resp_valid = 1, and resp_data is held stable.
  - The other requester's resp_valid = 0.
  - On owner resp_ready = 1: go to IDLE. A new grant is possible no earlier than the following cycle (no bypass).
  - While resp_ready = 0, stay in RESP indefinitely; both req_ready outputs stay 0.
- Timing: with grant at cycle T, mem_valid is asserted at T+LATENCY and resp_valid at T+LATENCY+1.
- Back-to-back throughput: minimum LATENCY+2 cycles per transaction.
- mem_* outputs:
  - Registered from the latched fields.
  - Hold their values outside the strobe cycle; mem_wen is only meaningful when mem_valid = 1.
- Requester deasserts valid in IDLE before a handshake: no grant, and last_grant is unchanged.
- Reset asserted in WAIT or RESP:
  - Transaction dropped; return to IDLE.
  - No mem_valid is issued and no response is delivered.
  - A memory strobe already issued is not undone.
- A response is never delivered to the non-owner. At most one mem_valid is issued per granted request.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, WAIT, RESP);
  - grant enum (GNT_IFU, GNT_LSU);
  - constant IFU_RMASK = 8'h0F;
  - constant for the counter width (4 bits).
- Sub-module rr_arb2:
  - 2-input round-robin picker.
  - Inputs: two valids and last_grant. Outputs: one-hot grant.
  - Purely combinational; last_grant is held in mem_arbiter.

Test Plan:
- LSU read, LATENCY=1, addr 0x80000008, mask 8'hFF, mem_rdata 0x1122334455667788:
  - mem_valid at T+1 with wen 0;
  - lsu_resp_valid at T+2 with data 0x1122334455667788;
  - ifu_resp_valid stays 0.
- LSU store, LATENCY=3, addr 0x80001000, wdata 0xDEADBEEF, mask 8'h0F:
  - exactly one mem_valid cycle at T+3 with wen 1 and mask 8'h0F;
  - response at T+4 with data 0.
- IFU and LSU both valid, persistently, from reset:
  - grant order LSU, IFU, LSU, IFU;
  - IFU strobes carry mask 8'h0F and wen 0.
- Hold lsu_resp_ready low for 10 cycles during RESP while ifu_req_valid = 1:
  - lsu_resp_valid and its data stay stable;
  - ifu_req_ready stays 0;
  - IFU is granted the cycle after lsu_resp_ready rises.
- Assert reset in WAIT, LATENCY=4, after 2 cycles:
  - outputs return to 0 immediately;
  - no mem_valid and no response are produced;
  - after release, the next request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IFU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

   // Instruction fetches read a 32-bit word.
   localparam logic [7:0] IFU_RMASK = 8'h0F;
   localparam int         CNT_W     = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin picker; ties go to the side not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic ifu_valid_i,
   input  logic lsu_valid_i,
   input  logic last_grant_i,
   output logic ifu_gnt_o,
   output logic lsu_gnt_o
);

   assign ifu_gnt_o = ifu_valid_i & (~lsu_valid_i | (last_grant_i == GNT_LSU));
   assign lsu_gnt_o = lsu_valid_i & (~ifu_valid_i | (last_grant_i == GNT_IFU));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Sequences IFU/LSU accesses onto one memory port, one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_resp_data,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic              lsu_req_wen,
   input  logic [DATA_W-1:0] lsu_req_wdata,
   input  logic [7:0]        lsu_req_mask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_resp_data,
   output logic              mem_valid,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_mask,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   grant_e            last_grant_q;
   grant_e            owner_q;
   logic              mem_valid_q;
   logic              mem_wen_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [7:0]        mem_mask_q;
   logic              ifu_resp_valid_q;
   logic              lsu_resp_valid_q;
   logic [DATA_W-1:0] ifu_resp_data_q;
   logic [DATA_W-1:0] lsu_resp_data_q;
   logic              ifu_gnt;
   logic              lsu_gnt;

   rr_arb2 u_rr_arb2 (
      .ifu_valid_i  (ifu_req_valid),
      .lsu_valid_i  (lsu_req_valid),
      .last_grant_i (last_grant_q),
      .ifu_gnt_o    (ifu_gnt),
      .lsu_gnt_o    (lsu_gnt)
   );

   assign ifu_req_ready  = (state_q == IDLE) & ifu_gnt;
   assign lsu_req_ready  = (state_q == IDLE) & lsu_gnt;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign ifu_resp_data  = ifu_resp_data_q;
   assign lsu_resp_data  = lsu_resp_data_q;
   assign mem_valid      = mem_valid_q;
   assign mem_wen        = mem_wen_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_mask       = mem_mask_q;

   // The mem_* field registers double as the latched request; the strobe is
   // raised one edge ahead so it coincides with the counter reaching zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         last_grant_q     <= GNT_IFU;
         owner_q          <= GNT_IFU;
         mem_valid_q      <= 1'b0;
         mem_wen_q        <= 1'b0;
         mem_addr_q       <= '0;
         mem_wdata_q      <= '0;
         mem_mask_q       <= '0;
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         ifu_resp_data_q  <= '0;
         lsu_resp_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ifu_gnt) begin
                  owner_q      <= GNT_IFU;
                  last_grant_q <= GNT_IFU;
                  mem_addr_q   <= ifu_req_addr;
                  mem_wen_q    <= 1'b0;
                  mem_wdata_q  <= '0;
                  mem_mask_q   <= IFU_RMASK;
               end else if (lsu_gnt) begin
                  owner_q      <= GNT_LSU;
                  last_grant_q <= GNT_LSU;
                  mem_addr_q   <= lsu_req_addr;
                  mem_wen_q    <= lsu_req_wen;
                  mem_wdata_q  <= lsu_req_wdata;
                  mem_mask_q   <= lsu_req_mask;
               end
               if (ifu_gnt || lsu_gnt) begin
                  cnt_q       <= CNT_LOAD;
                  mem_valid_q <= (CNT_LOAD == '0);
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     mem_valid_q <= 1'b1;
                  end
               end else begin
                  mem_valid_q <= 1'b0;
                  if (owner_q == GNT_IFU) begin
                     ifu_resp_valid_q <= 1'b1;
                     ifu_resp_data_q  <= mem_rdata;
                  end else begin
                     lsu_resp_valid_q <= 1'b1;
                     lsu_resp_data_q  <= mem_wen_q ? '0 : mem_rdata;
                  end
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (owner_q == GNT_IFU && ifu_resp_ready) begin
                  ifu_resp_valid_q <= 1'b0;
                  state_q          <= IDLE;
               end else if (owner_q == GNT_LSU && lsu_resp_ready) begin
                  lsu_resp_valid_q <= 1'b0;
                  state_q          <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Three arbiter instances (LATENCY 1/3/4) against a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   logic        ifu_req_valid  [3];
   logic        ifu_req_ready  [3];
   logic [63:0] ifu_req_addr   [3];
   logic        ifu_resp_valid [3];
   logic        ifu_resp_ready [3];
   logic [63:0] ifu_resp_data  [3];
   logic        lsu_req_valid  [3];
   logic        lsu_req_ready  [3];
   logic [63:0] lsu_req_addr   [3];
   logic        lsu_req_wen    [3];
   logic [63:0] lsu_req_wdata  [3];
   logic [7:0]  lsu_req_mask   [3];
   logic        lsu_resp_valid [3];
   logic        lsu_resp_ready [3];
   logic [63:0] lsu_resp_data  [3];
   logic        mem_valid      [3];
   logic        mem_wen        [3];
   logic [63:0] mem_addr       [3];
   logic [63:0] mem_wdata      [3];
   logic [7:0]  mem_mask       [3];
   logic [63:0] mem_rdata      [3];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [63:0] memfun(input logic [63:0] a);
      if (a == 64'h0000_0000_8000_0008) return 64'h1122334455667788;
      return {a[31:0] ^ 32'hA5A5A5A5, a[31:0]};
   endfunction

   task automatic chk1(input string nm, input int j, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s inst%0d t=%0t got=%b exp=%b", nm, j, $time, got, exp);
      end
   endtask

   task automatic chk64(input string nm, input int j, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s inst%0d t=%0t got=%h exp=%h", nm, j, $time, got, exp);
      end
   endtask

   for (genvar j = 0; j < 3; j++) begin : g_dut
      localparam int LAT = (j == 0) ? 1 : (j == 1) ? 3 : 4;

      mem_arbiter #(.LATENCY(LAT), .ADDR_W(64), .DATA_W(64)) u_dut (
         .clock          (clock),
         .reset          (reset),
         .ifu_req_valid  (ifu_req_valid[j]),
         .ifu_req_ready  (ifu_req_ready[j]),
         .ifu_req_addr   (ifu_req_addr[j]),
         .ifu_resp_valid (ifu_resp_valid[j]),
         .ifu_resp_ready (ifu_resp_ready[j]),
         .ifu_resp_data  (ifu_resp_data[j]),
         .lsu_req_valid  (lsu_req_valid[j]),
         .lsu_req_ready  (lsu_req_ready[j]),
         .lsu_req_addr   (lsu_req_addr[j]),
         .lsu_req_wen    (lsu_req_wen[j]),
         .lsu_req_wdata  (lsu_req_wdata[j]),
         .lsu_req_mask   (lsu_req_mask[j]),
         .lsu_resp_valid (lsu_resp_valid[j]),
         .lsu_resp_ready (lsu_resp_ready[j]),
         .lsu_resp_data  (lsu_resp_data[j]),
         .mem_valid      (mem_valid[j]),
         .mem_wen        (mem_wen[j]),
         .mem_addr       (mem_addr[j]),
         .mem_wdata      (mem_wdata[j]),
         .mem_mask       (mem_mask[j]),
         .mem_rdata      (mem_rdata[j])
      );

      assign mem_rdata[j] = memfun(mem_addr[j]);

      // Transaction model: one outstanding access, strobe at grant+LAT,
      // response from grant+LAT+1 until the owner accepts it.
      initial begin : p_model
         logic        busy, own_l, last_l, g_i, g_l, e_mv, e_rv, e_wen;
         logic [63:0] e_addr, e_wdata, e_rdata;
         logic [7:0]  e_mask;
         int          tg;
         busy = 1'b0; own_l = 1'b0; last_l = 1'b0; e_wen = 1'b0;
         e_addr = '0; e_wdata = '0; e_rdata = '0; e_mask = '0; tg = 0;
         forever begin
            @(negedge clock);
            if (!reset) begin
               busy   = 1'b0;
               last_l = 1'b0;
               chk1 ("rst_ifu_ready", j, ifu_req_ready[j], 1'b0);
               chk1 ("rst_lsu_ready", j, lsu_req_ready[j], 1'b0);
               chk1 ("rst_mem_valid", j, mem_valid[j], 1'b0);
               chk1 ("rst_ifu_rvalid", j, ifu_resp_valid[j], 1'b0);
               chk1 ("rst_lsu_rvalid", j, lsu_resp_valid[j], 1'b0);
               chk64("rst_mem_addr", j, mem_addr[j], 64'h0);
               chk64("rst_ifu_rdata", j, ifu_resp_data[j], 64'h0);
               chk64("rst_lsu_rdata", j, lsu_resp_data[j], 64'h0);
            end else begin
               g_i = 1'b0;
               g_l = 1'b0;
               if (!busy) begin
                  if (ifu_req_valid[j] && (!lsu_req_valid[j] || last_l)) g_i = 1'b1;
                  else if (lsu_req_valid[j]) g_l = 1'b1;
               end
               e_mv = busy && (cyc == tg + LAT);
               e_rv = busy && (cyc > tg + LAT);
               chk1("ifu_ready", j, ifu_req_ready[j], g_i);
               chk1("lsu_ready", j, lsu_req_ready[j], g_l);
               chk1("mem_valid", j, mem_valid[j], e_mv);
               chk1("ifu_rvalid", j, ifu_resp_valid[j], e_rv && !own_l);
               chk1("lsu_rvalid", j, lsu_resp_valid[j], e_rv && own_l);
               if (e_mv) begin
                  chk64("mem_addr", j, mem_addr[j], e_addr);
                  chk1 ("mem_wen", j, mem_wen[j], e_wen);
                  chk64("mem_mask", j, 64'(mem_mask[j]), 64'(e_mask));
                  if (e_wen) chk64("mem_wdata", j, mem_wdata[j], e_wdata);
               end
               if (e_rv) begin
                  if (own_l) chk64("lsu_rdata", j, lsu_resp_data[j], e_rdata);
                  else       chk64("ifu_rdata", j, ifu_resp_data[j], e_rdata);
                  if (own_l ? lsu_resp_ready[j] : ifu_resp_ready[j]) busy = 1'b0;
               end
               if (g_i || g_l) begin
                  busy   = 1'b1;
                  tg     = cyc;
                  own_l  = g_l;
                  last_l = g_l;
                  if (g_i) begin
                     e_addr = ifu_req_addr[j]; e_wen = 1'b0; e_mask = 8'h0F; e_wdata = '0;
                  end else begin
                     e_addr = lsu_req_addr[j]; e_wen = lsu_req_wen[j];
                     e_mask = lsu_req_mask[j]; e_wdata = lsu_req_wdata[j];
                  end
                  e_rdata = e_wen ? 64'h0 : memfun(e_addr);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drv_lsu(input int j, input logic v, input logic [63:0] a, input logic w,
                          input logic [63:0] wd, input logic [7:0] m);
      lsu_req_valid[j] = v;
      lsu_req_addr[j]  = a;
      lsu_req_wen[j]   = w;
      lsu_req_wdata[j] = wd;
      lsu_req_mask[j]  = m;
   endtask

   initial begin : p_main
      logic seq [4];
      logic exp_seq [4];
      int   gcyc [4];
      int   ng, nmv, t0;
      logic got_it;
      reset = 1'b0;
      for (int j = 0; j < 3; j++) begin
         ifu_req_valid[j] = 1'b0; ifu_req_addr[j] = '0; ifu_resp_ready[j] = 1'b0;
         lsu_resp_ready[j] = 1'b0;
         drv_lsu(j, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00);
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      tick();

      // LSU read, LATENCY=1
      drv_lsu(0, 1'b1, 64'h80000008, 1'b0, 64'h0, 8'hFF);
      lsu_resp_ready[0] = 1'b1;
      @(negedge clock);
      chk1("t1_grant", 0, lsu_req_ready[0], 1'b1);
      tick();
      lsu_req_valid[0] = 1'b0;
      @(negedge clock);
      chk1 ("t1_mv", 0, mem_valid[0], 1'b1);
      chk1 ("t1_wen", 0, mem_wen[0], 1'b0);
      chk64("t1_addr", 0, mem_addr[0], 64'h80000008);
      @(negedge clock);
      chk1 ("t1_rv", 0, lsu_resp_valid[0], 1'b1);
      chk64("t1_data", 0, lsu_resp_data[0], 64'h1122334455667788);
      chk1 ("t1_ifu_rv", 0, ifu_resp_valid[0], 1'b0);
      tick();
      lsu_resp_ready[0] = 1'b0;
      tick();

      // LSU store, LATENCY=3
      drv_lsu(1, 1'b1, 64'h80001000, 1'b1, 64'hDEADBEEF, 8'h0F);
      lsu_resp_ready[1] = 1'b1;
      @(negedge clock);
      chk1("t2_grant", 1, lsu_req_ready[1], 1'b1);
      tick();
      lsu_req_valid[1] = 1'b0;
      nmv = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         if (mem_valid[1]) begin
            nmv++;
            chk64("t2_mv_cycle", 1, 64'(k), 64'd3);
            chk1 ("t2_wen", 1, mem_wen[1], 1'b1);
            chk64("t2_mask", 1, 64'(mem_mask[1]), 64'h0F);
         end
         if (k == 4) begin
            chk1 ("t2_rv", 1, lsu_resp_valid[1], 1'b1);
            chk64("t2_data", 1, lsu_resp_data[1], 64'h0);
         end
      end
      chk64("t2_nstrobe", 1, 64'(nmv), 64'd1);
      tick();
      lsu_resp_ready[1] = 1'b0;

      // Persistent tie from reset: LSU, IFU, LSU, IFU
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ifu_req_valid[0] = 1'b1; ifu_req_addr[0] = 64'h80000100; ifu_resp_ready[0] = 1'b1;
      drv_lsu(0, 1'b1, 64'h80000200, 1'b0, 64'h0, 8'hFF);
      lsu_resp_ready[0] = 1'b1;
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
      ng = 0;
      for (int k = 0; k < 40 && ng < 4; k++) begin
         @(negedge clock);
         if (mem_valid[0] && mem_addr[0] == 64'h80000100) begin
            chk64("t3_ifu_mask", 0, 64'(mem_mask[0]), 64'h0F);
            chk1 ("t3_ifu_wen", 0, mem_wen[0], 1'b0);
         end
         if (ifu_req_ready[0] || lsu_req_ready[0]) begin
            seq[ng]  = ifu_req_ready[0];
            gcyc[ng] = cyc;
            ng++;
         end
      end
      chk64("t3_ngrants", 0, 64'(ng), 64'd4);
      for (int k = 0; k < 4 && k < ng; k++) chk1("t3_order", 0, seq[k], exp_seq[k]);
      for (int k = 1; k < 4 && k < ng; k++) chk64("t3_spacing", 0, 64'(gcyc[k] - gcyc[k-1]), 64'd3);
      tick();
      ifu_req_valid[0] = 1'b0;
      lsu_req_valid[0] = 1'b0;
      repeat (5) tick();

      // Response backpressure with IFU waiting
      drv_lsu(0, 1'b1, 64'h80000300, 1'b0, 64'h0, 8'hFF);
      lsu_resp_ready[0] = 1'b0;
      @(negedge clock);
      chk1("t4_grant", 0, lsu_req_ready[0], 1'b1);
      tick();
      lsu_req_valid[0] = 1'b0;
      ifu_req_valid[0] = 1'b1; ifu_req_addr[0] = 64'h80000400;
      got_it = 1'b0;
      for (int k = 0; k < 10 && !got_it; k++) begin
         @(negedge clock);
         got_it = lsu_resp_valid[0];
      end
      chk1("t4_resp_seen", 0, got_it, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk1 ("t4_hold_rv", 0, lsu_resp_valid[0], 1'b1);
         chk64("t4_hold_data", 0, lsu_resp_data[0], 64'h25A5A6A580000300);
         chk1 ("t4_ifu_blocked", 0, ifu_req_ready[0], 1'b0);
      end
      tick();
      lsu_resp_ready[0] = 1'b1;
      @(negedge clock);
      chk1("t4_no_bypass", 0, ifu_req_ready[0], 1'b0);
      tick();
      lsu_resp_ready[0] = 1'b0;
      @(negedge clock);
      chk1("t4_ifu_grant", 0, ifu_req_ready[0], 1'b1);
      tick();
      ifu_req_valid[0] = 1'b0;
      repeat (4) tick();

      // Reset during WAIT, LATENCY=4
      drv_lsu(2, 1'b1, 64'h80000500, 1'b0, 64'h0, 8'hFF);
      lsu_resp_ready[2] = 1'b1;
      @(negedge clock);
      chk1("t5_grant", 2, lsu_req_ready[2], 1'b1);
      tick();
      lsu_req_valid[2] = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk1 ("t5_async_mv", 2, mem_valid[2], 1'b0);
      chk1 ("t5_async_rv", 2, lsu_resp_valid[2], 1'b0);
      chk64("t5_async_addr", 2, mem_addr[2], 64'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk1("t5_no_mv", 2, mem_valid[2], 1'b0);
         chk1("t5_no_rv", 2, lsu_resp_valid[2], 1'b0);
         tick();
         if (k == 1) reset = 1'b1;
      end
      drv_lsu(2, 1'b1, 64'h80002000, 1'b1, 64'h0123456789ABCDEF, 8'hF0);
      @(negedge clock);
      chk1("t5_regrant", 2, lsu_req_ready[2], 1'b1);
      t0 = cyc;
      tick();
      lsu_req_valid[2] = 1'b0;
      got_it = 1'b0;
      for (int k = 0; k < 20 && !got_it; k++) begin
         @(negedge clock);
         got_it = lsu_resp_valid[2];
      end
      chk1 ("t5_resp_seen", 2, got_it, 1'b1);
      chk64("t5_latency", 2, 64'(cyc - t0), 64'd5);
      chk64("t5_data", 2, lsu_resp_data[2], 64'h0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
